// File: rtl/gcd_lcm_cop_if.sv
// rtl/gcd_lcm_cop_if.sv - controller <-> GCD/LCM coprocessor request/result bundle
interface gcd_lcm_cop_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op_lcm;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             busy;
  logic             lcm_ovf;

  modport master (
    output start, op_lcm, src_a, src_b,
    input  result, done, busy, lcm_ovf
  );

  modport slave (
    input  start, op_lcm, src_a, src_b,
    output result, done, busy, lcm_ovf
  );
endinterface

// File: rtl/gcd_lcm_cop.sv
// rtl/gcd_lcm_cop.sv - multi-cycle subtractive-Euclid GCD/LCM coprocessor
module gcd_lcm_cop #(
  parameter int WIDTH = 32
) (
  input logic          clk_i,
  input logic          reset_i,
  gcd_lcm_cop_if.slave cop
);
  // u/v accumulators need 2*WIDTH+1 bits; u+v at termination is 2*LCM.
  localparam int AW = 2 * WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [AW-1:0]    u_q, u_d;
  logic [AW-1:0]    v_q, v_d;
  logic             op_lcm_q, op_lcm_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;

  // u+v is always even at termination, so its LSB is dropped by the halving.
  logic [AW:0]      lcm_sum;
  logic             lcm_sum_unused;
  assign lcm_sum        = {1'b0, u_q} + {1'b0, v_q};
  assign lcm_sum_unused = lcm_sum[0];

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      u_q      <= '0;
      v_q      <= '0;
      op_lcm_q <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      u_q      <= u_d;
      v_q      <= v_d;
      op_lcm_q <= op_lcm_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next state: operand load, one Euclid/Dijkstra step per cycle, result capture.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    u_d      = u_q;
    v_d      = v_q;
    op_lcm_d = op_lcm_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (cop.start) begin
          if ((cop.src_a != '0) && (cop.src_b != '0)) begin
            x_d      = cop.src_a;
            y_d      = cop.src_b;
            u_d      = {{(AW-WIDTH){1'b0}}, cop.src_b};
            v_d      = {{(AW-WIDTH){1'b0}}, cop.src_a};
            op_lcm_d = cop.op_lcm;
            state_d  = S_CALC;
          end else begin
            // A zero operand short-cuts: GCD(a,0)=a, LCM with zero is zero.
            result_d = cop.op_lcm ? '0 : (cop.src_a | cop.src_b);
            ovf_d    = 1'b0;
            state_d  = S_DONE;
          end
        end
      end
      S_CALC: begin
        if (x_q == y_q) begin
          result_d = op_lcm_q ? lcm_sum[WIDTH:1] : x_q;
          ovf_d    = op_lcm_q & (|lcm_sum[AW:WIDTH+1]);
          state_d  = S_DONE;
        end else if (x_q > y_q) begin
          x_d = x_q - y_q;
          v_d = v_q + u_q;
        end else begin
          y_d = y_q - x_q;
          u_d = u_q + v_q;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign cop.result  = result_q;
  assign cop.lcm_ovf = ovf_q;
  assign cop.done    = (state_q == S_DONE);
  assign cop.busy    = (state_q != S_IDLE);
endmodule

// File: tb/tb_gcd_lcm_cop.sv
// tb/tb_gcd_lcm_cop.sv - randomized self-checking bench for gcd_lcm_cop
module tb_gcd_lcm_cop;
  logic clk;
  logic reset;
  int   n_vec;
  int   n_miss;

  gcd_lcm_cop_if #(.WIDTH(32)) bus32 ();
  gcd_lcm_cop_if #(.WIDTH(8))  bus8 ();

  gcd_lcm_cop #(.WIDTH(32)) u_dut32 (.clk_i(clk), .reset_i(reset), .cop(bus32.slave));
  gcd_lcm_cop #(.WIDTH(8))  u_dut8  (.clk_i(clk), .reset_i(reset), .cop(bus8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint unsigned gcd_ref(input longint unsigned a, input longint unsigned b);
    longint unsigned t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Subtraction steps of subtractive Euclid = sum of division quotients, minus the final one.
  function automatic int steps_ref(input longint unsigned a, input longint unsigned b);
    longint unsigned t;
    longint unsigned n;
    n = 0;
    while (b != 0) begin
      n += a / b;
      t = a % b;
      a = b;
      b = t;
    end
    return int'(n) - 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sel_done(input bit w8);
    return w8 ? bus8.done : bus32.done;
  endfunction

  function automatic logic sel_busy(input bit w8);
    return w8 ? bus8.busy : bus32.busy;
  endfunction

  function automatic logic [31:0] sel_result(input bit w8);
    return w8 ? {24'd0, bus8.result} : bus32.result;
  endfunction

  function automatic logic sel_ovf(input bit w8);
    return w8 ? bus8.lcm_ovf : bus32.lcm_ovf;
  endfunction

  task automatic drive(input bit w8, input logic [31:0] a, input logic [31:0] b,
                       input bit lcm, input bit st);
    if (w8) begin
      bus8.src_a = a[7:0]; bus8.src_b = b[7:0]; bus8.op_lcm = lcm; bus8.start = st;
    end else begin
      bus32.src_a = a; bus32.src_b = b; bus32.op_lcm = lcm; bus32.start = st;
    end
  endtask

  // Counts edges until done; returns -1 when the bound expires.
  task automatic wait_done(input bit w8, input int limit, input bit rel_start,
                           input bit toggle_a, output int k);
    k = -1;
    for (int i = 1; i <= limit; i++) begin
      step();
      if (i == 1 && rel_start) begin
        bus32.start = 1'b0;
        bus8.start  = 1'b0;
      end
      if (toggle_a) bus32.src_a = $urandom;
      if (sel_done(w8)) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic expect_op(input bit w8, input logic [31:0] a, input logic [31:0] b, input bit lcm,
                           output logic [31:0] res, output logic ovf, output int lat);
    longint unsigned g, l;
    if (a == 0 || b == 0) begin
      res = lcm ? 32'd0 : (a | b);
      ovf = 1'b0;
      lat = 1;
    end else begin
      g   = gcd_ref(a, b);
      l   = (longint'(a) / g) * longint'(b);
      lat = steps_ref(a, b) + 2;
      if (!lcm) begin
        res = g[31:0];
        ovf = 1'b0;
      end else if (w8) begin
        res = {24'd0, l[7:0]};
        ovf = (l >> 8) != 0;
      end else begin
        res = l[31:0];
        ovf = (l >> 32) != 0;
      end
    end
  endtask

  task automatic run_op(input bit w8, input logic [31:0] a, input logic [31:0] b,
                        input bit lcm, input string tag);
    logic [31:0] er;
    logic        eo;
    int          el, k;
    expect_op(w8, a, b, lcm, er, eo, el);
    drive(w8, a, b, lcm, 1'b1);
    wait_done(w8, el + 20, 1'b1, 1'b0, k);
    check_eq({tag, " latency"}, 64'(k), 64'(el));
    check_eq({tag, " result"}, 64'(sel_result(w8)), 64'(er));
    check_eq({tag, " ovf"}, 64'(sel_ovf(w8)), 64'(eo));
    step();
    check_eq({tag, " done pulse"}, 64'(sel_done(w8)), 64'd0);
    check_eq({tag, " idle busy"}, 64'(sel_busy(w8)), 64'd0);
    check_eq({tag, " result hold"}, 64'(sel_result(w8)), 64'(er));
  endtask

  initial begin
    int          k;
    logic [31:0] a, b, g, p, q, mx;
    bit          lcm;
    n_vec  = 0;
    n_miss = 0;
    reset  = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    drive(1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
    step();
    step();
    check_eq("reset result32", 64'(bus32.result), 64'd0);
    check_eq("reset done32", 64'(bus32.done), 64'd0);
    check_eq("reset busy32", 64'(bus32.busy), 64'd0);
    check_eq("reset ovf32", 64'(bus32.lcm_ovf), 64'd0);
    check_eq("reset result8", 64'(bus8.result), 64'd0);
    reset = 1'b0;
    step();

    // Directed cases from the reference examples.
    drive(1'b0, 32'd12, 32'd18, 1'b0, 1'b1);
    step();
    bus32.start = 1'b0;
    check_eq("t1 busy e1", 64'(bus32.busy), 64'd1);
    wait_done(1'b0, 20, 1'b0, 1'b0, k);
    check_eq("t1 latency", 64'(k + 1), 64'd4);
    check_eq("t1 result", 64'(bus32.result), 64'd6);
    check_eq("t1 busy done", 64'(bus32.busy), 64'd1);
    step();
    check_eq("t1 done pulse", 64'(bus32.done), 64'd0);
    run_op(1'b0, 32'd4, 32'd6, 1'b1, "t2 lcm4_6");
    run_op(1'b0, 32'd7, 32'd0, 1'b0, "t3 gcd7_0");
    run_op(1'b0, 32'd0, 32'd9, 1'b1, "t3 lcm0_9");
    run_op(1'b0, 32'd0, 32'd0, 1'b0, "t3 gcd0_0");
    run_op(1'b1, 32'd255, 32'd254, 1'b1, "t4 lcm8");
    run_op(1'b1, 32'd255, 32'd254, 1'b0, "t4 gcd8");
    run_op(1'b0, 32'd1, 32'd200, 1'b0, "gcd1_200");

    // Back-to-back ops with start held; operands change in the DONE cycle.
    drive(1'b0, 32'd12, 32'd18, 1'b0, 1'b1);
    wait_done(1'b0, 20, 1'b0, 1'b0, k);
    check_eq("t5 first latency", 64'(k), 64'd4);
    check_eq("t5 first result", 64'(bus32.result), 64'd6);
    drive(1'b0, 32'd4, 32'd6, 1'b1, 1'b1);
    step();
    check_eq("t5 idle done", 64'(bus32.done), 64'd0);
    check_eq("t5 idle busy", 64'(bus32.busy), 64'd0);
    check_eq("t5 idle result", 64'(bus32.result), 64'd6);
    wait_done(1'b0, 20, 1'b1, 1'b0, k);
    check_eq("t5 second latency", 64'(k), 64'd4);
    check_eq("t5 second result", 64'(bus32.result), 64'd12);
    step();

    // Operand A toggles while the engine is running.
    drive(1'b0, 32'd48, 32'd36, 1'b0, 1'b1);
    wait_done(1'b0, 30, 1'b1, 1'b1, k);
    check_eq("t5 toggle latency", 64'(k), 64'd5);
    check_eq("t5 toggle result", 64'(bus32.result), 64'd12);
    step();

    // Reset in the middle of a computation.
    drive(1'b0, 32'd100, 32'd3, 1'b0, 1'b1);
    step();
    bus32.start = 1'b0;
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("t6 done", 64'(bus32.done), 64'd0);
    check_eq("t6 busy", 64'(bus32.busy), 64'd0);
    check_eq("t6 result", 64'(bus32.result), 64'd0);
    run_op(1'b0, 32'd100, 32'd3, 1'b0, "t6 rerun");

    // Random small operands (short runs, occasional zero).
    for (int i = 0; i < 20; i++) begin
      a   = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom_range(1, 300);
      b   = $urandom_range(1, 300);
      lcm = 1'($urandom);
      run_op(1'b0, a, b, lcm, $sformatf("rnd%0d a=%0d b=%0d lcm=%0d", i, a, b, lcm));
    end

    // Random large operands sharing a big common factor (LCM may overflow).
    for (int i = 0; i < 16; i++) begin
      p   = $urandom_range(1, 15);
      q   = $urandom_range(1, 15);
      mx  = 32'hFFFF_FFFF / ((p > q) ? p : q);
      g   = $urandom_range(1, mx);
      a   = g * p;
      b   = g * q;
      lcm = (i % 4) != 0;
      run_op(1'b0, a, b, lcm, $sformatf("big%0d a=%0d b=%0d lcm=%0d", i, a, b, lcm));
    end

    // Random 8-bit operands on the narrow instance.
    for (int i = 0; i < 8; i++) begin
      a   = $urandom_range(1, 255);
      b   = $urandom_range(1, 255);
      run_op(1'b1, a, b, 1'b1, $sformatf("w8_%0d a=%0d b=%0d", i, a, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
